// File: rtl/outlier_drain.sv
// outlier_drain: pops outlier indices from a 1-cycle-latency FIFO onto a valid/ready stream.
// Define OUTLIER_DRAIN_RANGE_CHECK_EN to filter indices >= point_cloud_size and expose range_err.
module outlier_drain #(
    parameter int unsigned N             = 16,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ctrl_done,
    input  logic           fifo_empty,
    input  logic [N-1:0]   fifo_dout,
    output logic           fifo_rd_en,
    input  logic [2*N-1:0] point_cloud_size,
    output logic           m_valid,
    output logic [N-1:0]   m_data,
    input  logic           m_ready,
    output logic [2*N-1:0] outlier_count,
    output logic           drain_done
`ifdef OUTLIER_DRAIN_RANGE_CHECK_EN
    ,
    output logic           range_err
`endif
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1) + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  settle_q, settle_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic           skid_valid_q, skid_valid_d;
    logic [N-1:0]   skid_data_q, skid_data_d;
    logic           inflight_q, inflight_d;
    logic [2*N-1:0] count_q, count_d;

    logic           accept;
    logic           in_range;
    logic           ret_valid;
    logic           idle;
    logic           rd_en;
    logic [1:0]     occ_raw;
    logic [1:0]     occ_rd;

`ifdef OUTLIER_DRAIN_RANGE_CHECK_EN
    logic range_err_q, range_err_d;

    assign in_range    = ({{N{1'b0}}, fifo_dout} < point_cloud_size);
    assign range_err_d = range_err_q | (inflight_q & ~in_range);
    assign range_err   = range_err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end
`else
    logic unused_pcs;

    assign in_range   = 1'b1;
    assign unused_pcs = ^point_cloud_size;
`endif

    assign ret_valid = inflight_q && in_range;
    assign m_valid   = out_valid_q && (state_q != ST_DONE);
    assign accept    = m_valid && m_ready;

    // Read gating treats an OUT entry accepted this cycle as already free,
    // which is what sustains one index per cycle under continuous m_ready.
    assign occ_raw = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(inflight_q);
    assign occ_rd  = 2'(out_valid_q && !accept) + 2'(skid_valid_q) + 2'(inflight_q);
    assign idle    = fifo_empty && (occ_raw == 2'd0);
    assign rd_en   = !reset && !fifo_empty && (occ_rd < 2'd2) && (state_q != ST_DONE);

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        inflight_d   = rd_en;
        count_d      = count_q;

        if (accept) begin
            if (count_q != '1) begin
                count_d = count_q + (2*N)'(1);
            end
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                skid_valid_d = ret_valid;
                if (ret_valid) begin
                    skid_data_d = fifo_dout;
                end
            end else if (ret_valid) begin
                out_data_d = fifo_dout;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (ret_valid) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = fifo_dout;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = fifo_dout;
            end
        end
    end

    // The cycle in which ctrl_done is first seen idle counts toward the settle window.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;

        case (state_q)
            ST_RUN: begin
                if (ctrl_done) begin
                    if (idle && (SETTLE_CYCLES <= 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_SETTLE;
                        settle_d = idle ? CW'(SETTLE_CYCLES - 1) : CW'(SETTLE_CYCLES);
                    end
                end
            end
            ST_SETTLE: begin
                if (!ctrl_done) begin
                    state_d = ST_RUN;
                end else if (!idle) begin
                    settle_d = CW'(SETTLE_CYCLES);
                end else if (settle_q <= CW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    settle_d = settle_q - CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            settle_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            inflight_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
        end
    end

    assign fifo_rd_en    = rd_en;
    assign m_data        = out_data_q;
    assign outlier_count = count_q;
    assign drain_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_outlier_drain.sv
// Scoreboard bench for outlier_drain: directed FIFO contents, monitor checks delivered order.
module tb_outlier_drain;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_done;
    logic        fifo_empty;
    logic [15:0] fifo_dout = '0;
    logic        fifo_rd_en;
    logic [31:0] pcs;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic [31:0] outlier_count;
    logic        drain_done;
`ifdef OUTLIER_DRAIN_RANGE_CHECK_EN
    logic        range_err;
`endif

    outlier_drain #(.N(16), .SETTLE_CYCLES(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_done        (ctrl_done),
        .fifo_empty       (fifo_empty),
        .fifo_dout        (fifo_dout),
        .fifo_rd_en       (fifo_rd_en),
        .point_cloud_size (pcs),
        .m_valid          (m_valid),
        .m_data           (m_data),
        .m_ready          (m_ready),
        .outlier_count    (outlier_count),
        .drain_done       (drain_done)
`ifdef OUTLIER_DRAIN_RANGE_CHECK_EN
        ,
        .range_err        (range_err)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural standard-mode FIFO: data appears the cycle after rd_en.
    logic [15:0] mem [0:63];
    int unsigned wp = 0;
    int unsigned rp = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clock) begin
        if (fifo_rd_en && (wp != rp)) begin
            fifo_dout <= mem[rp[5:0]];
            rp        <= rp + 1;
        end
    end

    logic [15:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [15:0] v, input bit delivered);
        mem[wp[5:0]] = v;
        wp = wp + 1;
        if (delivered) exp_q.push_back(v);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        m_ready   = 1'b0;
        ctrl_done = 1'b0;
        tick();
        tick();
        exp_q.delete();
    endtask

    // Monitor: scoreboard pop on every accepted beat, plus stream stability.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;

    always @(negedge clock) begin
        if (fifo_rd_en) check("rd_on_empty", 64'(fifo_empty), 64'(0));
        if (prev_stall && !reset) begin
            check("stall_valid", 64'(m_valid), 64'(1));
            check("stall_data", 64'(m_data), 64'(prev_data));
        end
        if (m_valid && m_ready && !reset) begin
            check("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check("sb_data", 64'(m_data), 64'(exp_q.pop_front()));
        end
        prev_stall = m_valid && !m_ready && !reset;
        prev_data  = m_data;
    end

    logic        t1_rd [1:6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        t1_mv [1:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] t1_md [1:6] = '{16'd0, 16'd0, 16'd3, 16'd7, 16'd12, 16'd0};
    logic        t2_pat [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          nrd;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Test 1: reset values with a non-empty FIFO, then full-rate drain of 3,7,12.
        reset = 1'b1; m_ready = 1'b0; ctrl_done = 1'b0; pcs = '1;
        tick();
        push(16'd3, 1'b1); push(16'd7, 1'b1); push(16'd12, 1'b1);
        #2;
        check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_count", 64'(outlier_count), 64'(0));
        check("rst_done", 64'(drain_done), 64'(0));
`ifdef OUTLIER_DRAIN_RANGE_CHECK_EN
        check("rst_range_err", 64'(range_err), 64'(0));
`endif
        tick();
        reset = 1'b0; m_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            #2;
            check("t1_rd_en", 64'(fifo_rd_en), 64'(t1_rd[c]));
            check("t1_m_valid", 64'(m_valid), 64'(t1_mv[c]));
            if (t1_mv[c]) check("t1_m_data", 64'(m_data), 64'(t1_md[c]));
            if (c == 6) check("t1_count", 64'(outlier_count), 64'(3));
            tick();
        end
        check("t1_sb_drained", 64'(exp_q.size()), 64'(0));

        // Test 2: long stall then toggled ready; order and backpressure.
        do_reset();
        push(16'd3, 1'b1); push(16'd7, 1'b1); push(16'd12, 1'b1);
        reset = 1'b0; m_ready = 1'b0; nrd = 0;
        for (int c = 1; c <= 6; c++) begin
            #2;
            if (fifo_rd_en) nrd++;
            tick();
        end
        #2;
        check("t2_rd_before_accept", 64'(nrd), 64'(2));
        check("t2_hold_valid", 64'(m_valid), 64'(1));
        check("t2_hold_data", 64'(m_data), 64'(3));
        for (int i = 0; i < 6; i++) begin
            m_ready = t2_pat[i];
            tick();
        end
        m_ready = 1'b1;
        repeat (4) tick();
        #2;
        check("t2_count", 64'(outlier_count), 64'(3));
        check("t2_idle_valid", 64'(m_valid), 64'(0));
        check("t2_sb_drained", 64'(exp_q.size()), 64'(0));

        // Test 3: empty FIFO, ctrl_done at cycle 10 -> drain_done at cycle 12.
        do_reset();
        reset = 1'b0; m_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 10) ctrl_done = 1'b1;
            #2;
            if (c >= 10) check("t3_done_timing", 64'(drain_done), 64'(c == 12));
            if (c == 12) begin
                check("t3_done_rd_en", 64'(fifo_rd_en), 64'(0));
                check("t3_done_valid", 64'(m_valid), 64'(0));
                check("t3_count", 64'(outlier_count), 64'(0));
            end
            tick();
        end
        ctrl_done = 1'b0;
        repeat (3) tick();
        #2;
        check("t3_done_sticky", 64'(drain_done), 64'(1));

        // Test 4: ctrl_done drops during settle -> back to normal running.
        do_reset();
        reset = 1'b0; m_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            ctrl_done = (c == 1) || (c >= 7);
            #2;
            if (c >= 3 && c <= 8) check("t4_no_done", 64'(drain_done), 64'(0));
            if (c == 9) check("t4_done_after_retry", 64'(drain_done), 64'(1));
            tick();
        end

        // Test 5: index 5 arrives one cycle after ctrl_done.
        do_reset();
        reset = 1'b0; m_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            if (c == 1) ctrl_done = 1'b1;
            if (c == 2) push(16'd5, 1'b1);
            #2;
            if (c == 6) check("t5_not_done_yet", 64'(drain_done), 64'(0));
            if (c == 7) begin
                check("t5_done", 64'(drain_done), 64'(1));
                check("t5_count", 64'(outlier_count), 64'(1));
            end
            tick();
        end
        check("t5_sb_drained", 64'(exp_q.size()), 64'(0));

        // Test 6: reset while OUT holds 9 and 11 is returning from the FIFO.
        do_reset();
        reset = 1'b0; m_ready = 1'b0;
        push(16'd9, 1'b1); push(16'd11, 1'b1);
        for (int c = 1; c <= 2; c++) begin
            #2;
            check("t6_rd_en", 64'(fifo_rd_en), 64'(1));
            tick();
        end
        #2;
        check("t6_out_valid", 64'(m_valid), 64'(1));
        check("t6_out_data", 64'(m_data), 64'(9));
        reset = 1'b1;
        tick();
        reset = 1'b0; m_ready = 1'b1;
        exp_q.delete();
        #2;
        check("t6_post_rst_valid", 64'(m_valid), 64'(0));
        check("t6_post_rst_count", 64'(outlier_count), 64'(0));
        for (int c = 0; c < 5; c++) begin
            tick();
            #2;
            check("t6_no_late_out", 64'(m_valid), 64'(0));
        end
        check("t6_final_count", 64'(outlier_count), 64'(0));

`ifdef OUTLIER_DRAIN_RANGE_CHECK_EN
        // Test 7: point_cloud_size=10 filters index 10, keeps 4 and 2.
        do_reset();
        pcs = 32'd10;
        reset = 1'b0; m_ready = 1'b1;
        push(16'd4, 1'b1); push(16'd10, 1'b0); push(16'd2, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            #2;
            if (c == 3) check("t7_err_before", 64'(range_err), 64'(0));
            if (c == 5) check("t7_err_set", 64'(range_err), 64'(1));
            tick();
        end
        #2;
        check("t7_err_sticky", 64'(range_err), 64'(1));
        check("t7_count", 64'(outlier_count), 64'(2));
        check("t7_sb_drained", 64'(exp_q.size()), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
